bitset_index_encoder: RTL and testbench

BITSET_INDEX_ENCODER -- requirements
Module: bitset_index_encoder

---
 rtl/bitset_index_pkg.sv | 11 +
 rtl/bitset_index_encoder_lsb_finder.sv | 25 ++
 rtl/bitset_index_encoder.sv | 95 +++++++++
 tb/tb_bitset_index_encoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitset_index_pkg.sv
// Shared types for the bitset index encoder.
// Holds the controller state type that the encoder top and its users import.
package bitset_index_pkg;

  // IDLE: waiting for a vector. EMIT: streaming set-bit indices of pend.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1
  } state_t;

endpackage : bitset_index_pkg

// File: rtl/bitset_index_encoder_lsb_finder.sv
// lsb_finder: purely combinational lowest-set-bit locator.
// Ports:
//   vec   - input vector, WIDTH bits
//   index - position of the lowest set bit of vec (0 when vec is zero)
//   any   - 1 when at least one bit of vec is set
module lsb_finder #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  index,
  output logic             any
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    index = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (vec[i-1]) index = IDXW'(i - 1);
    end
  end

  assign any = |vec;

endmodule : lsb_finder

// File: rtl/bitset_index_encoder.sv
// bitset_index_encoder: captures a bit vector and emits the index of every
// set bit, lowest first, one beat per output handshake. An all-zero vector
// yields a single beat flagged with out_none.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - input handshake, in_vec is the vector to enumerate
//   out_valid / out_ready - output handshake
//   out_index             - index of the current set bit
//   out_last              - final beat of the frame
//   out_none              - frame came from an all-zero vector
module bitset_index_encoder
  import bitset_index_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last,
  output logic             out_none
);

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic             none_q;

  logic [IDXW-1:0]  low_idx;
  logic             any_set;
  logic             emit;
  logic             single;
  logic [WIDTH-1:0] pend_drop_low;

  lsb_finder #(.WIDTH(WIDTH)) u_lsb (
    .vec   (pend),
    .index (low_idx),
    .any   (any_set)
  );

  // Clearing the lowest set bit; result is zero iff pend has <= 1 bit set.
  assign pend_drop_low = pend & (pend - WIDTH'(1));
  assign single        = (pend_drop_low == '0);
  assign emit          = (state == EMIT);

  // Outputs are functions of registers only; in_ready alone sees out_ready,
  // which lets a new vector land on the last beat without an idle gap.
  assign out_valid = emit;
  assign out_index = (emit && any_set) ? low_idx : '0;
  assign out_last  = emit & single;
  assign out_none  = emit & none_q;
  assign in_ready  = ~emit | (out_ready & single);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend   <= '0;
      none_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pend   <= in_vec;
            none_q <= ~|in_vec;
            state  <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!single) begin
              pend <= pend_drop_low;
            end else if (in_valid) begin
              pend   <= in_vec;
              none_q <= ~|in_vec;
            end else begin
              pend   <= '0;
              none_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          pend   <= '0;
          none_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule : bitset_index_encoder

// File: tb/tb_bitset_index_encoder.sv
// Scoreboard bench for bitset_index_encoder (WIDTH=8): a driver presents
// queued vectors, accepted vectors are expanded by a reference model into
// expected beats, and a monitor checks every cycle against the queue head.
module tb_bitset_index_encoder;

  localparam int W = 8;

  typedef struct {
    int idx;
    bit last;
    bit none;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_index;
  logic         out_last;
  logic         out_none;

  bitset_index_encoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int beat_cnt = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit gap_en   = 1'b0;

  logic [W-1:0] vec_q[$];
  beat_t        exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one beat per set bit in ascending order, or a single
  // "none" beat for an empty vector.
  task automatic model_push(input logic [W-1:0] v);
    int remaining;
    beat_t b;
    remaining = $countones(v);
    if (remaining == 0) begin
      b.idx = 0; b.last = 1'b1; b.none = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < W; i++) begin
        if (v[i]) begin
          b.idx = i; b.last = (remaining == 1); b.none = 1'b0;
          exp_q.push_back(b);
          remaining--;
        end
      end
    end
  endtask

  // Input driver
  initial begin
    in_valid = 1'b0;
    in_vec   = '0;
    forever begin
      @(posedge clk); #1;
      if (vec_q.size() != 0 && (!gap_en || in_valid || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        in_vec   = vec_q[0];
      end else begin
        in_valid = 1'b0;
        in_vec   = W'($urandom);
      end
    end
  end

  // Output-ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Acceptance observer: pushes expected beats for every accepted vector.
  always @(negedge clk) begin
    #2;
    if (rst_n && in_valid && in_ready) begin
      model_push(in_vec);
      if (vec_q.size() != 0) void'(vec_q.pop_front());
    end
  end

  // Monitor: compares DUT against the scoreboard head every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      chk("in_ready", int'(in_ready),
          int'(exp_q.size() == 0 || (out_ready && exp_q.size() == 1)));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_index", int'(out_index), exp_q[0].idx);
        chk("out_last", int'(out_last), int'(exp_q[0].last));
        chk("out_none", int'(out_none), int'(exp_q[0].none));
        if (out_ready) begin
          void'(exp_q.pop_front());
          beat_cnt++;
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk); #3;
      if (vec_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_in_ready"},  int'(in_ready),  1);
    chk({tag, "_out_index"}, int'(out_index), 0);
    chk({tag, "_out_last"},  int'(out_last),  0);
    chk({tag, "_out_none"},  int'(out_none),  0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Sparse vector, always ready: beats 2, 5, 7.
    rdy_mode = 0;
    vec_q.push_back(8'hA4);
    wait_idle(40);

    // Empty vector: single none beat.
    vec_q.push_back(8'h00);
    wait_idle(40);

    // Stall on the first beat, then drain: beats 1, 4.
    rdy_mode = 2;
    vec_q.push_back(8'h12);
    repeat (6) @(posedge clk);
    #2;
    chk("stall_out_valid", int'(out_valid), 1);
    chk("stall_out_index", int'(out_index), 1);
    rdy_mode = 0;
    wait_idle(40);

    // Back-to-back: second vector accepted on the last beat of the first.
    vec_q.push_back(8'h80);
    vec_q.push_back(8'h01);
    wait_idle(40);

    // Reset mid-frame after three beats of 0xFF.
    beat_cnt = 0;
    vec_q.push_back(8'hFF);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(posedge clk);
        if (beat_cnt >= 3) seen = 1'b1;
      end
      if (!seen) chk("beat3_timeout", 0, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    vec_q.delete();
    check_reset_outputs("midreset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("post_reset_beats", beat_cnt, 3);

    // Full vector: eight beats 0..7.
    vec_q.push_back(8'hFF);
    wait_idle(40);

    // Randomised traffic with gaps and backpressure.
    gap_en   = 1'b1;
    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       vec_q.push_back(8'h00);
        1:       vec_q.push_back(8'hFF);
        default: vec_q.push_back(W'($urandom));
      endcase
    end
    wait_idle(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule : tb_bitset_index_encoder
